// File: rtl/i2s_rx_pkg.sv
// Shared audio sample definitions, common to the I2S receive and transmit blocks.
// Holds the default slot/sample widths, the stereo sample record carried on the
// stream interface, and the receiver's frame-tracking state codes.
package i2s_rx_pkg;

    localparam int DEF_SLOT_BITS   = 32;
    localparam int DEF_SAMPLE_BITS = 24;

    // One stereo sample pair, left channel in the upper half.
    typedef struct packed {
        logic signed [DEF_SAMPLE_BITS-1:0] lc;
        logic signed [DEF_SAMPLE_BITS-1:0] rc;
    } sample_t;

    // Frame-tracking states, kept as plain constants for older tools.
    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    // Where a word start leads from a given state: a falling lrck always opens
    // a left word, a rising lrck only advances a left word into its right word.
    function automatic logic [1:0] word_start_state(input logic [1:0] cur,
                                                    input logic       lr);
        logic [1:0] nxt;
        if (!lr) begin
            nxt = ST_LEFT;
        end else if (cur == ST_LEFT) begin
            nxt = ST_RIGHT;
        end else begin
            nxt = ST_SYNC;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal valid/ready stream carrying one stereo sample pair per beat.
interface axis_if;
    import i2s_rx_pkg::*;

    logic    vld;
    logic    rdy;
    sample_t data;

    modport master (output vld, output data, input rdy);
    modport slave  (input vld, input data, output rdy);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing one asynchronous bit into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async input through two flops to let metastability settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples the codec's sclk/lrck/sdi with the system clock,
// recovers left/right words MSB-first after the one-bit I2S delay, and hands
// complete stereo pairs out on a valid/ready stream. A left word must be fully
// captured before its right word can produce an output beat; short words
// raise frame_err and force a resync, and an unconsumed beat that gets
// replaced raises overrun.
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int SLOT_BITS   = DEF_SLOT_BITS,
    parameter int SAMPLE_BITS = DEF_SAMPLE_BITS
) (
    input  logic   clk,
    input  logic   rst,
    axis_if.master axis_rx,
    input  logic   sclk,
    input  logic   lrck,
    input  logic   sdi,
    output logic   overrun,
    output logic   frame_err
);

    // The bit counter is sized for a whole slot but saturates at SAMPLE_BITS.
    localparam int               CNT_W    = $clog2(SLOT_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_BITS - 1);

    logic                   sclk_s;
    logic                   lrck_s;
    logic                   sdi_s;
    logic                   sclk_d;
    logic                   lrck_prev;
    logic                   tick;
    logic                   word_start;
    logic                   word_short;
    logic                   word_done;
    logic                   frame_load;
    logic [1:0]             state;
    logic [1:0]             state_next;
    logic                   err_next;
    logic [CNT_W-1:0]       bit_cnt;
    logic [SAMPLE_BITS-1:0] shift;
    logic [SAMPLE_BITS-1:0] lc_hold;
    logic                   lc_valid;

    sync_2ff u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
    sync_2ff u_sync_lrck (.clk(clk), .rst(rst), .d(lrck), .q(lrck_s));
    sync_2ff u_sync_sdi  (.clk(clk), .rst(rst), .d(sdi),  .q(sdi_s));

    // All three inputs share the same synchronizer depth, so sdi_s and lrck_s
    // are already aligned with the sclk rising edge seen on sclk_s.
    assign tick       = sclk_s & ~sclk_d;
    assign word_start = tick & (lrck_s != lrck_prev);
    assign word_short = (bit_cnt < CNT_FULL);
    assign frame_load = word_done & (state == ST_RIGHT) & lc_valid;

    // Remember the previous sclk level and the lrck level at the last tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d    <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            if (tick) begin
                lrck_prev <= lrck_s;
            end
        end
    end

    // Drop the delay bit at a word start, then shift sample bits in MSB-first
    // until the counter saturates; trailing slot bits are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift     <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= tick & ~word_start & (bit_cnt == CNT_LAST);
            if (word_start) begin
                bit_cnt <= '0;
            end else if (tick && word_short) begin
                shift   <= {shift[SAMPLE_BITS-2:0], sdi_s};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // A short word ends in SYNC first, then the same word start is re-applied
    // so a falling lrck can still open a fresh left word on that very tick.
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        if (word_start) begin
            if ((state != ST_SYNC) && word_short) begin
                err_next   = 1'b1;
                state_next = word_start_state(ST_SYNC, lrck_s);
            end else begin
                state_next = word_start_state(state, lrck_s);
            end
        end
    end

    // Advance frame tracking and emit the one-clk frame error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_SYNC;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            frame_err <= err_next;
        end
    end

    // Park a complete left word until its right partner arrives; the left
    // word stays usable only across a clean LEFT-to-RIGHT word start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lc_hold  <= '0;
            lc_valid <= 1'b0;
        end else if (word_start) begin
            if (err_next || (state_next != ST_RIGHT)) begin
                lc_valid <= 1'b0;
            end
        end else if (word_done && (state == ST_LEFT)) begin
            lc_hold  <= shift;
            lc_valid <= 1'b1;
        end else if (frame_load) begin
            lc_valid <= 1'b0;
        end
    end

    // Present each stereo pair until accepted; a new pair replacing one that
    // is not being accepted this clk is flagged as an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axis_rx.vld  <= 1'b0;
            axis_rx.data <= '0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_load) begin
                axis_rx.data.lc <= lc_hold;
                axis_rx.data.rc <= shift;
                axis_rx.vld     <= 1'b1;
                overrun         <= axis_rx.vld & ~axis_rx.rdy;
            end else if (axis_rx.vld && axis_rx.rdy) begin
                axis_rx.vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for the I2S receiver: drives codec-style word slots (lrck/sdi change
// while sclk is low, sclk = clk/8) and checks every accepted beat against a
// word-level model of which stereo pairs the receiver must deliver.
module tb_i2s_rx;
    import i2s_rx_pkg::*;

    localparam int SB   = DEF_SAMPLE_BITS;
    localparam int SLOT = DEF_SLOT_BITS;

    logic clk;
    logic rst;
    logic sclk;
    logic lrck;
    logic sdi;
    logic overrun;
    logic frame_err;

    axis_if axis_rx_if ();

    i2s_rx #(.SLOT_BITS(SLOT), .SAMPLE_BITS(SB)) dut (
        .clk      (clk),
        .rst      (rst),
        .axis_rx  (axis_rx_if),
        .sclk     (sclk),
        .lrck     (lrck),
        .sdi      (sdi),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    int checks   = 0;
    int failures = 0;

    // Word-level model: which words were opened by a visible lrck edge, which
    // were long enough, and the resulting queue of pairs the DUT owes us.
    sample_t          exp_q[$];
    logic             m_prev_lr;
    logic             m_tracked;
    logic             m_prev_complete;
    logic             m_left_ok;
    logic [SB-1:0]    m_left;
    int               exp_ferr = 0;

    // Observed behaviour, accumulated by the compare process.
    int               obs_beats = 0;
    int               obs_ovr   = 0;
    int               obs_ferr  = 0;
    sample_t          last_beat;
    int               rdy_mode;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ready pattern: 0 = held low, 1 = held high, 2 = toggling every clk.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       axis_rx_if.rdy = 1'b0;
                1:       axis_rx_if.rdy = 1'b1;
                default: axis_rx_if.rdy = ~axis_rx_if.rdy;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_prev_lr       = 1'b0;
        m_tracked       = 1'b0;
        m_prev_complete = 1'b1;
        m_left_ok       = 1'b0;
        m_left          = '0;
    endtask

    // Drive one word slot of nper sclk periods: a delay bit, then the sample
    // MSB-first, then filler ones. The model books the pair the moment the
    // last sample bit is clocked.
    task automatic applyStimulus(input logic lr, input logic [SB-1:0] value, input int nper);
        logic started;
        logic tracked;
        started   = (lr != m_prev_lr);
        m_prev_lr = lr;
        tracked   = 1'b0;
        if (started) begin
            if (m_tracked && !m_prev_complete) exp_ferr++;
            tracked   = lr ? m_left_ok : 1'b1;
            m_left_ok = 1'b0;
        end
        m_tracked       = tracked;
        m_prev_complete = (nper >= SB + 1);
        for (int k = 0; k < nper; k++) begin
            sclk = 1'b0;
            lrck = lr;
            sdi  = (k >= 1 && k <= SB) ? value[SB-k] : 1'b1;
            #40;
            sclk = 1'b1;
            if (k == SB && tracked) begin
                if (!lr) begin
                    m_left    = value;
                    m_left_ok = 1'b1;
                end else begin
                    exp_q.push_back('{lc: m_left, rc: value});
                end
            end
            #40;
        end
    endtask

    task automatic send_frame(input logic [SB-1:0] l, input logic [SB-1:0] r);
        applyStimulus(1'b0, l, SLOT);
        applyStimulus(1'b1, r, SLOT);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_vld"},       axis_rx_if.vld,  1'b0);
        checkOutput({tag, "_data"},      axis_rx_if.data, '0);
        checkOutput({tag, "_overrun"},   overrun,         1'b0);
        checkOutput({tag, "_frame_err"}, frame_err,       1'b0);
    endtask

    // Compare process: every clk, account overruns and frame errors, insist a
    // stalled beat holds steady, and match each accepted beat to the model.
    initial begin : compare
        sample_t prev_data;
        logic    prev_hold;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (frame_err) obs_ferr++;
                if (overrun) begin
                    obs_ovr++;
                    checkOutput("overrun_has_newer_pair", exp_q.size() >= 2, 1'b1);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else if (prev_hold) begin
                    checkOutput("stall_vld_held", axis_rx_if.vld, 1'b1);
                    checkOutput("stall_data_held", axis_rx_if.data, prev_data);
                end
                if (axis_rx_if.vld && axis_rx_if.rdy) begin
                    checkOutput("beat_was_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        checkOutput("beat_data", axis_rx_if.data, exp_q.pop_front());
                    end
                    obs_beats++;
                    last_beat = axis_rx_if.data;
                end
                prev_hold = axis_rx_if.vld & ~axis_rx_if.rdy;
                prev_data = axis_rx_if.data;
            end
        end
    end

    initial begin
        rst = 1'b1;
        sclk = 1'b0;
        lrck = 1'b0;
        sdi = 1'b0;
        rdy_mode = 1;
        axis_rx_if.rdy = 1'b1;
        last_beat = '0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // Start mid-way through a right word: nothing until a full pair.
        applyStimulus(1'b1, 24'h777777, 15);
        checkOutput("midword_no_beat", obs_beats, 0);
        send_frame(24'h654321, 24'h0FEDCB);
        repeat (20) @(posedge clk);
        checkOutput("midword_beats", obs_beats, 1);
        checkOutput("midword_first_pair", last_beat, {24'h654321, 24'h0FEDCB});

        // Plain frame with ready held high.
        send_frame(24'h123456, 24'hABCDEF);
        repeat (20) @(posedge clk);
        checkOutput("basic_one_beat", obs_beats, 2);
        checkOutput("basic_pair", last_beat, {24'h123456, 24'hABCDEF});
        checkOutput("basic_vld_low", axis_rx_if.vld, 1'b0);

        // Left word cut short after 10 bits, then a good frame.
        applyStimulus(1'b0, 24'hC0FFEE, 11);
        applyStimulus(1'b1, 24'h5A5A5A, SLOT);
        checkOutput("short_no_beat", obs_beats, 2);
        send_frame(24'h13579B, 24'h2468AC);
        repeat (20) @(posedge clk);
        checkOutput("short_ferr_pulses", obs_ferr, 1);
        checkOutput("short_ferr_model", obs_ferr, exp_ferr);
        checkOutput("short_recovered_pair", last_beat, {24'h13579B, 24'h2468AC});

        // Two frames while ready is low: the second replaces the first.
        rdy_mode = 0;
        send_frame(24'h0A0A0A, 24'h0B0B0B);
        send_frame(24'h1C1C1C, 24'h2D2D2D);
        repeat (20) @(posedge clk);
        checkOutput("ovr_pulses", obs_ovr, 1);
        checkOutput("ovr_vld_pending", axis_rx_if.vld, 1'b1);
        checkOutput("ovr_data_is_b", axis_rx_if.data, {24'h1C1C1C, 24'h2D2D2D});
        rdy_mode = 1;
        repeat (6) @(posedge clk);
        checkOutput("ovr_delivered", obs_beats, 4);
        checkOutput("ovr_pair_b", last_beat, {24'h1C1C1C, 24'h2D2D2D});
        checkOutput("ovr_vld_cleared", axis_rx_if.vld, 1'b0);

        // Reset during the 12th right bit, then a fresh frame.
        applyStimulus(1'b0, 24'h111111, SLOT);
        applyStimulus(1'b1, 24'h222222, 12);
        sclk = 1'b0;
        sdi  = 1'b1;
        #40;
        sclk = 1'b1;
        #20;
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        applyStimulus(1'b1, 24'h000000, 20);
        checkOutput("midreset_dropped", obs_beats, 4);
        send_frame(24'h000001, 24'hFFFFFF);
        repeat (20) @(posedge clk);
        checkOutput("midreset_beats", obs_beats, 5);
        checkOutput("midreset_pair", last_beat, {24'h000001, 24'hFFFFFF});

        // Back-to-back frames with ready toggling every clk.
        rdy_mode = 2;
        for (int f = 0; f < 4; f++) begin
            send_frame(24'h100000 + 24'(f), 24'h800000 - 24'(f));
        end
        repeat (20) @(posedge clk);
        rdy_mode = 1;
        repeat (4) @(posedge clk);
        checkOutput("b2b_beats", obs_beats, 9);
        checkOutput("b2b_last_pair", last_beat, {24'h100003, 24'h7FFFFD});
        checkOutput("b2b_no_new_overrun", obs_ovr, 1);

        checkOutput("end_queue_drained", exp_q.size(), 0);
        checkOutput("end_ferr_total", obs_ferr, exp_ferr);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
